// File: rtl/kbd_calc_core.sv
// Keyboard calculator datapath: PS/2 make codes in, two N-digit decimal operands,
// multi-cycle BCD->binary, ALU and double-dabble, blanked BCD display out.
module kbd_calc_core #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [8:0]            key_code,
  output logic [8*DIGITS-1:0]   disp_bcd,
  output logic [2*DIGITS-1:0]   digit_en,
  output logic                  neg,
  output logic                  busy,
  output logic                  result_valid,
  output logic [1:0]            op_code,
  output logic [2:0]            state_o
);

  localparam int unsigned OP_W  = 4 * DIGITS;
  localparam int unsigned RES_W = 8 * DIGITS;
  localparam int unsigned EN_W  = 2 * DIGITS;
  localparam int unsigned DD_W  = RES_W + BIN_W;
  localparam int unsigned CA_W  = $clog2(DIGITS + 1);
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_CONV    = 3'd2,
    S_CALC    = 3'd3,
    S_BCD     = 3'd4,
    S_SHOW    = 3'd5
  } state_t;

  state_t            r_state, w_state;
  logic [OP_W-1:0]   r_a, w_a, r_b, w_b;
  logic [CA_W-1:0]   r_cnt_a, w_cnt_a, r_cnt_b, w_cnt_b;
  logic [1:0]        w_op;
  logic [BIN_W-1:0]  r_acc_a, w_acc_a, r_acc_b, w_acc_b;
  logic [BIN_W-1:0]  r_res, w_res;
  logic              r_sign, w_sign;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [DD_W-1:0]   r_dd, w_dd, w_dd_step;
  logic [RES_W-1:0]  w_disp;
  logic [EN_W-1:0]   w_en;
  logic              w_neg, w_rv, w_clear;

  logic              w_is_dig, w_is_op, w_is_ent, w_is_bs, w_is_esc;
  logic [3:0]        w_dig;
  logic [1:0]        w_op_key;
  logic              w_kd, w_kop, w_kent, w_kbs, w_kesc;

  // One shift-add-3 iteration over the whole {bcd, binary} field
  function automatic logic [DD_W-1:0] f_dd_step(input logic [DD_W-1:0] v);
    logic [DD_W-1:0] t;
    t = v;
    for (int i = 0; i < int'(EN_W); i++) begin
      if (t[BIN_W+4*i +: 4] >= 4'd5) t[BIN_W+4*i +: 4] = t[BIN_W+4*i +: 4] + 4'd3;
    end
    return {t[DD_W-2:0], 1'b0};
  endfunction

  function automatic logic [EN_W-1:0] f_entry_mask(input logic [CA_W-1:0] cnt);
    logic [EN_W-1:0] m;
    m = '0;
    for (int i = 0; i < int'(EN_W); i++) m[i] = (i == 0) || (i < int'(cnt));
    return m;
  endfunction

  // Blank leading zeros; digit 0 always lit
  function automatic logic [EN_W-1:0] f_lz_mask(input logic [RES_W-1:0] bcd);
    logic [EN_W-1:0] m;
    logic            seen;
    m    = '0;
    seen = 1'b0;
    for (int i = int'(EN_W) - 1; i >= 0; i--) begin
      if (bcd[4*i +: 4] != 4'd0) seen = 1'b1;
      m[i] = seen || (i == 0);
    end
    return m;
  endfunction

  // Make-code decode
  always_comb begin
    w_is_dig = 1'b0;
    w_dig    = 4'd0;
    w_is_op  = 1'b0;
    w_op_key = 2'd0;
    w_is_ent = 1'b0;
    w_is_bs  = 1'b0;
    w_is_esc = 1'b0;
    case (key_code)
      9'h045, 9'h070: begin w_is_dig = 1'b1; w_dig = 4'd0; end
      9'h016, 9'h069: begin w_is_dig = 1'b1; w_dig = 4'd1; end
      9'h01E, 9'h072: begin w_is_dig = 1'b1; w_dig = 4'd2; end
      9'h026, 9'h07A: begin w_is_dig = 1'b1; w_dig = 4'd3; end
      9'h025, 9'h06B: begin w_is_dig = 1'b1; w_dig = 4'd4; end
      9'h02E, 9'h073: begin w_is_dig = 1'b1; w_dig = 4'd5; end
      9'h036, 9'h074: begin w_is_dig = 1'b1; w_dig = 4'd6; end
      9'h03D, 9'h06C: begin w_is_dig = 1'b1; w_dig = 4'd7; end
      9'h03E, 9'h075: begin w_is_dig = 1'b1; w_dig = 4'd8; end
      9'h046, 9'h07D: begin w_is_dig = 1'b1; w_dig = 4'd9; end
      9'h079:         begin w_is_op  = 1'b1; w_op_key = 2'd0; end
      9'h07B:         begin w_is_op  = 1'b1; w_op_key = 2'd1; end
      9'h07C:         begin w_is_op  = 1'b1; w_op_key = 2'd2; end
      9'h05A, 9'h15A: w_is_ent = 1'b1;
      9'h066:         w_is_bs  = 1'b1;
      9'h076:         w_is_esc = 1'b1;
      default: ;
    endcase
  end

  assign w_kd   = key_valid & w_is_dig;
  assign w_kop  = key_valid & w_is_op;
  assign w_kent = key_valid & w_is_ent;
  assign w_kbs  = key_valid & w_is_bs;
  assign w_kesc = key_valid & w_is_esc;

  // Next-state and datapath
  always_comb begin
    w_state   = r_state;
    w_a       = r_a;
    w_b       = r_b;
    w_cnt_a   = r_cnt_a;
    w_cnt_b   = r_cnt_b;
    w_op      = op_code;
    w_acc_a   = r_acc_a;
    w_acc_b   = r_acc_b;
    w_res     = r_res;
    w_sign    = r_sign;
    w_cnt     = r_cnt;
    w_dd      = r_dd;
    w_disp    = disp_bcd;
    w_en      = digit_en;
    w_neg     = neg;
    w_rv      = 1'b0;
    w_clear   = 1'b0;
    w_dd_step = f_dd_step(r_dd);

    case (r_state)
      S_ENTER_A: begin
        if (w_kd) begin
          if (r_cnt_a < CA_W'(DIGITS)) begin
            w_a     = {r_a[OP_W-5:0], w_dig};
            w_cnt_a = r_cnt_a + CA_W'(1);
          end
        end else if (w_kbs) begin
          if (r_cnt_a != '0) begin
            w_a     = r_a >> 4;
            w_cnt_a = r_cnt_a - CA_W'(1);
          end
        end else if (w_kop) begin
          if (r_cnt_a != '0) begin
            w_op    = w_op_key;
            w_state = S_ENTER_B;
          end
        end else if (w_kesc) begin
          w_clear = 1'b1;
        end
      end
      S_ENTER_B: begin
        if (w_kd) begin
          if (r_cnt_b < CA_W'(DIGITS)) begin
            w_b     = {r_b[OP_W-5:0], w_dig};
            w_cnt_b = r_cnt_b + CA_W'(1);
          end
        end else if (w_kbs) begin
          if (r_cnt_b != '0) begin
            w_b     = r_b >> 4;
            w_cnt_b = r_cnt_b - CA_W'(1);
          end
        end else if (w_kop) begin
          if (r_cnt_b == '0) w_op = w_op_key;
        end else if (w_kent) begin
          if (r_cnt_b != '0) begin
            w_state = S_CONV;
            w_cnt   = '0;
            w_acc_a = '0;
            w_acc_b = '0;
          end
        end else if (w_kesc) begin
          w_clear = 1'b1;
        end
      end
      S_CONV: begin
        // Operands shift out MSD first; top digit feeds the accumulator
        w_a     = r_a << 4;
        w_b     = r_b << 4;
        w_acc_a = r_acc_a * BIN_W'(10) + BIN_W'(r_a[OP_W-1 -: 4]);
        w_acc_b = r_acc_b * BIN_W'(10) + BIN_W'(r_b[OP_W-1 -: 4]);
        w_cnt   = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(DIGITS - 1)) w_state = S_CALC;
      end
      S_CALC: begin
        w_sign = 1'b0;
        case (op_code)
          2'd1: begin
            if (r_acc_a < r_acc_b) begin
              w_res  = r_acc_b - r_acc_a;
              w_sign = 1'b1;
            end else begin
              w_res  = r_acc_a - r_acc_b;
            end
          end
          2'd2:    w_res = r_acc_a * r_acc_b;
          default: w_res = r_acc_a + r_acc_b;
        endcase
        w_cnt   = '0;
        w_state = S_BCD;
      end
      S_BCD: begin
        if (r_cnt == '0) begin
          w_dd  = {RES_W'(0), r_res};
          w_cnt = CNT_W'(1);
        end else begin
          w_dd  = w_dd_step;
          w_cnt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(BIN_W)) begin
            w_state = S_SHOW;
            w_disp  = w_dd_step[DD_W-1 -: RES_W];
            w_en    = f_lz_mask(w_dd_step[DD_W-1 -: RES_W]);
            w_neg   = r_sign;
            w_rv    = 1'b1;
          end
        end
      end
      S_SHOW: begin
        if (w_kd) begin
          w_clear = 1'b1;
        end else if (w_kesc) begin
          w_clear = 1'b1;
        end
      end
      default: w_state = S_ENTER_A;
    endcase

    if (w_clear) begin
      w_state = S_ENTER_A;
      w_a     = '0;
      w_b     = '0;
      w_cnt_a = '0;
      w_cnt_b = '0;
      w_op    = 2'd0;
      w_sign  = 1'b0;
      w_res   = '0;
      // A digit pressed while showing a result starts a fresh A operand
      if (r_state == S_SHOW && w_kd) begin
        w_a     = OP_W'(w_dig);
        w_cnt_a = CA_W'(1);
      end
    end

    if (w_state == S_ENTER_A) begin
      w_disp = RES_W'(w_a);
      w_en   = f_entry_mask(w_cnt_a);
      w_neg  = 1'b0;
    end else if (w_state == S_ENTER_B) begin
      w_disp = RES_W'(w_b);
      w_en   = f_entry_mask(w_cnt_b);
      w_neg  = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_ENTER_A;
      r_a          <= '0;
      r_b          <= '0;
      r_cnt_a      <= '0;
      r_cnt_b      <= '0;
      r_acc_a      <= '0;
      r_acc_b      <= '0;
      r_res        <= '0;
      r_sign       <= 1'b0;
      r_cnt        <= '0;
      r_dd         <= '0;
      op_code      <= 2'd0;
      disp_bcd     <= '0;
      digit_en     <= EN_W'(1);
      neg          <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      state_o      <= 3'd0;
    end else begin
      r_state      <= w_state;
      r_a          <= w_a;
      r_b          <= w_b;
      r_cnt_a      <= w_cnt_a;
      r_cnt_b      <= w_cnt_b;
      r_acc_a      <= w_acc_a;
      r_acc_b      <= w_acc_b;
      r_res        <= w_res;
      r_sign       <= w_sign;
      r_cnt        <= w_cnt;
      r_dd         <= w_dd;
      op_code      <= w_op;
      disp_bcd     <= w_disp;
      digit_en     <= w_en;
      neg          <= w_neg;
      busy         <= (w_state == S_CONV) || (w_state == S_CALC) || (w_state == S_BCD);
      result_valid <= w_rv;
      state_o      <= 3'(w_state);
    end
  end

endmodule

// File: tb/tb_kbd_calc_core.sv
// Directed bench for kbd_calc_core: key sequences in, expected results queued at Enter
// and compared when result_valid fires.
module tb_kbd_calc_core;

  localparam int unsigned DIGITS = 2;
  localparam int unsigned BIN_W  = 14;
  localparam int          LAT    = DIGITS + BIN_W + 2;

  localparam logic [8:0] K1 = 9'h016, K2 = 9'h01E, K3 = 9'h026, K4 = 9'h025;
  localparam logic [8:0] K5 = 9'h02E, K7 = 9'h03D, K9 = 9'h046, KP9 = 9'h07D;
  localparam logic [8:0] KADD = 9'h079, KSUB = 9'h07B, KMUL = 9'h07C;
  localparam logic [8:0] KENT = 9'h05A, KENTX = 9'h15A, KBS = 9'h066, KESC = 9'h076;

  typedef struct {
    logic [15:0] disp;
    logic [3:0]  en;
    logic        neg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [8:0]  key_code = 9'h0;
  logic [15:0] disp_bcd;
  logic [3:0]  digit_en;
  logic        neg, busy, result_valid;
  logic [1:0]  op_code;
  logic [2:0]  state_o;

  int   checks = 0;
  int   failures = 0;
  int   rv_count = 0;
  exp_t sb[$];

  kbd_calc_core #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .reset(rst_n), .key_valid(key_valid), .key_code(key_code),
    .disp_bcd(disp_bcd), .digit_en(digit_en), .neg(neg), .busy(busy),
    .result_valid(result_valid), .op_code(op_code), .state_o(state_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (result_valid === 1'b1) rv_count++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [8:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 9'h0;
  endtask

  task automatic chk_view(input string tag, input logic [15:0] d, input logic [3:0] e,
                          input logic n, input logic [2:0] s);
    chk({tag, "_disp"},  32'(disp_bcd), 32'(d));
    chk({tag, "_en"},    32'(digit_en), 32'(e));
    chk({tag, "_neg"},   32'(neg),      32'(n));
    chk({tag, "_state"}, 32'(state_o),  32'(s));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_view(tag, 16'h0000, 4'b0001, 1'b0, 3'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rv"},   32'(result_valid), 32'd0);
    chk({tag, "_op"},   32'(op_code), 32'd0);
  endtask

  // Push the expectation, press Enter, then wait for the result and score it
  task automatic run_calc(input string tag, input logic [15:0] d, input logic [3:0] e,
                          input logic n, input logic [8:0] ent, input bit inject);
    exp_t x, got;
    int   lat, bcnt, rv0;
    bit   found;
    x.disp = d; x.en = e; x.neg = n;
    sb.push_back(x);
    rv0   = rv_count;
    press(ent);
    lat   = -1;
    bcnt  = 0;
    found = 1'b0;
    for (int k = 0; k <= LAT + 10 && !found; k++) begin
      if (k > 0) @(negedge clk);
      if (inject) begin
        if (k == 8) begin
          chk({tag, "_in_bcd"}, 32'(state_o), 32'd4);
          key_valid = 1'b1;
          key_code  = K5;
        end else if (k == 9) begin
          key_code  = KESC;
        end else if (k == 10) begin
          key_valid = 1'b0;
          key_code  = 9'h0;
        end
      end
      if (busy) bcnt++;
      if (result_valid) begin
        found = 1'b1;
        lat   = k;
      end
    end
    chk({tag, "_rv_seen"}, 32'(found), 32'd1);
    got = sb.pop_front();
    chk({tag, "_disp"}, 32'(disp_bcd), 32'(got.disp));
    chk({tag, "_en"},   32'(digit_en), 32'(got.en));
    chk({tag, "_neg"},  32'(neg),      32'(got.neg));
    chk({tag, "_latency"}, 32'(lat),  32'(LAT));
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(LAT));
    chk({tag, "_show"}, 32'(state_o), 32'd5);
    @(negedge clk);
    chk({tag, "_rv_pulse"}, 32'(result_valid), 32'd0);
    chk({tag, "_rv_count"}, 32'(rv_count - rv0), 32'd1);
  endtask

  initial begin
    int rv0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Add 12 + 34
    press(K1); press(K2);
    chk_view("entry_a12", 16'h0012, 4'b0011, 1'b0, 3'd0);
    press(KADD);
    chk_view("op_add", 16'h0000, 4'b0001, 1'b0, 3'd1);
    chk("op_add_code", 32'(op_code), 32'd0);
    press(K3); press(K4);
    chk_view("entry_b34", 16'h0034, 4'b0011, 1'b0, 3'd1);
    run_calc("add", 16'h0046, 4'b0011, 1'b0, KENT, 1'b0);

    // Restart from SHOW with a digit
    press(K7);
    chk_view("restart7", 16'h0007, 4'b0001, 1'b0, 3'd0);
    press(KESC);
    chk_view("esc", 16'h0000, 4'b0001, 1'b0, 3'd0);

    // Subtract 12 - 34
    press(K1); press(K2); press(KSUB); press(K3); press(K4);
    chk("op_sub_code", 32'(op_code), 32'd1);
    run_calc("sub_neg", 16'h0022, 4'b0011, 1'b1, KENT, 1'b0);
    press(KMUL);
    chk_view("show_op_ignored", 16'h0022, 4'b0011, 1'b1, 3'd5);
    chk("show_op_code", 32'(op_code), 32'd1);
    press(KESC);
    chk_reset_vals("esc_show");

    // 9 - 9 with extended Enter
    press(K9); press(KSUB); press(K9);
    run_calc("sub_zero", 16'h0000, 4'b0001, 1'b0, KENTX, 1'b0);

    // Operator replacement while B empty, keypad digit
    press(KESC); press(K9); press(KADD); press(KMUL);
    chk("op_replace", 32'(op_code), 32'd2);
    press(KP9);
    chk_view("keypad9", 16'h0009, 4'b0001, 1'b0, 3'd1);
    run_calc("mul_81", 16'h0081, 4'b0011, 1'b0, KENT, 1'b0);

    // 99 * 99, then again with keys injected during BCD
    press(KESC); press(K9); press(K9); press(KMUL); press(K9); press(K9);
    run_calc("mul", 16'h9801, 4'b1111, 1'b0, KENT, 1'b0);
    press(KESC); press(K9); press(K9); press(KMUL); press(K9); press(K9);
    run_calc("mul_busy_drop", 16'h9801, 4'b1111, 1'b0, KENT, 1'b1);

    // Entry edits
    press(KESC); press(K1); press(K2); press(K3);
    chk_view("drop3", 16'h0012, 4'b0011, 1'b0, 3'd0);
    press(KBS);
    chk_view("bs1", 16'h0001, 4'b0001, 1'b0, 3'd0);
    press(KBS); press(KBS);
    chk_view("bs_empty", 16'h0000, 4'b0001, 1'b0, 3'd0);
    press(KADD);
    chk("op_at_zero", 32'(state_o), 32'd0);
    press(K1); press(KADD); press(KENT);
    chk_view("enter_ignored", 16'h0000, 4'b0001, 1'b0, 3'd1);

    // Reset in the middle of a multiply
    press(KESC); press(K9); press(K9); press(KMUL); press(K9); press(K9);
    press(KENT);
    rv0 = rv_count;
    repeat (10) @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_rv", 32'(rv_count - rv0), 32'd0);
    chk("abort_idle_state", 32'(state_o), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
